// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared data-SRAM bus widths, size encodings and response entry type.
package data_sram_responder_pkg;
  localparam int DSRAM_ADDR_WD = 32;
  localparam int DSRAM_DATA_WD = 32;
  localparam int DSRAM_STRB_WD = 4;
  typedef enum logic [1:0] {
    DSRAM_SIZE_B = 2'd0,
    DSRAM_SIZE_H = 2'd1,
    DSRAM_SIZE_W = 2'd2
  } dsram_size_e;
  typedef struct packed {
    logic [DSRAM_DATA_WD-1:0] data;
    logic [3:0]               wt;
  } resp_t;
  function automatic logic [DSRAM_DATA_WD-1:0] strb_merge(
    input logic [DSRAM_DATA_WD-1:0] old,
    input logic [DSRAM_DATA_WD-1:0] wd,
    input logic [DSRAM_STRB_WD-1:0] st
  );
    logic [DSRAM_DATA_WD-1:0] r;
    r = old;
    for (int b = 0; b < DSRAM_STRB_WD; b++)
      if (st[b]) r[8*b+:8] = wd[8*b+:8];
    return r;
  endfunction
endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: CPU data-side SRAM-like request/response bus.
interface data_sram_responder_if;
  import data_sram_responder_pkg::*;
  logic                     data_sram_req;
  logic                     data_sram_wr;
  logic [1:0]               data_sram_size;
  logic [DSRAM_ADDR_WD-1:0] data_sram_addr;
  logic [DSRAM_STRB_WD-1:0] data_sram_wstrb;
  logic [DSRAM_DATA_WD-1:0] data_sram_wdata;
  logic                     data_sram_addr_ok;
  logic                     data_sram_data_ok;
  logic [DSRAM_DATA_WD-1:0] data_sram_rdata;
  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_resp_queue.sv
// sram_resp_queue: in-order response FIFO whose entries count down to their release cycle.
module sram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DSRAM_DATA_WD-1:0] i_push_data,
  input  logic                     i_pop,
  output logic                     o_pop_ready,
  output logic [CW-1:0]            o_count,
  output logic [DSRAM_DATA_WD-1:0] o_head_data
);
  resp_t         r_q [DEPTH];
  resp_t         w_q [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_tail;
  assign w_tail = r_cnt - CW'(i_pop);
  // Head sits at index 0; a pop shifts everything down while all counters tick.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_q[j] = i_pop ? ((j + 1 < DEPTH) ? r_q[(j + 1) % DEPTH] : '0) : r_q[j];
      if (w_q[j].wt != 4'd0) w_q[j].wt = w_q[j].wt - 4'd1;
      if (i_push && w_tail == CW'(j)) w_q[j] = '{data: i_push_data, wt: 4'(LATENCY - 1)};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      for (int j = 0; j < DEPTH; j++) r_q[j] <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      r_q   <= w_q;
    end
  end
  assign o_pop_ready = (r_cnt != '0) && (r_q[0].wt == 4'd0);
  assign o_count     = r_cnt;
  assign o_head_data = r_q[0].data;
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-side SRAM responder with byte-strobed writes and fixed-latency in-order replies.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter int MAX_OUTST  = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_sram_responder_if.slave s
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic [DSRAM_DATA_WD-1:0] r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]    w_idx;
  logic                     w_acc;
  logic                     w_pop;
  logic [CW-1:0]            w_cnt;
  logic [DSRAM_DATA_WD-1:0] w_head;
  logic                     w_unused;
  assign w_idx    = s.data_sram_addr[DEPTH_LOG2+1:2];
  assign w_unused = ^{s.data_sram_size, s.data_sram_addr[DSRAM_ADDR_WD-1:DEPTH_LOG2+2], s.data_sram_addr[1:0]};
  // Full blocks acceptance even when the head leaves this cycle; addr_ok depends on state only.
  assign s.data_sram_addr_ok = w_cnt < CW'(MAX_OUTST);
  assign w_acc = s.data_sram_req && s.data_sram_addr_ok;
  always_ff @(posedge clk)
    if (w_acc && s.data_sram_wr)
      r_mem[w_idx] <= strb_merge(r_mem[w_idx], s.data_sram_wdata, s.data_sram_wstrb);
  sram_resp_queue #(.DEPTH(MAX_OUTST), .LATENCY(LATENCY)) u_queue (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_acc),
    .i_push_data (s.data_sram_wr ? '0 : r_mem[w_idx]),
    .i_pop       (w_pop),
    .o_pop_ready (w_pop),
    .o_count     (w_cnt),
    .o_head_data (w_head)
  );
  assign s.data_sram_data_ok = w_pop;
  assign s.data_sram_rdata   = w_pop ? w_head : '0;
endmodule
